// File: rtl/gate_send_stamp.sv
// Send-path stamper: looks up the sender's route capability, forwards authorised
// packets with the capability as tdest, and drains/counts everything else.
module gate_send_stamp #(
  parameter int unsigned DATA_BITS  = 512,
  parameter int unsigned LOOKUP_LAT = 1,
  parameter int unsigned CNT_BITS   = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [1:0]             s_ul_id,
  output logic [1:0]             ul_port_out,
  input  logic [7:0]             route_in,
  output logic [DATA_BITS-1:0]   m_axis_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [7:0]             m_axis_tdest,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  input  logic                   cnt_clr,
  output logic [CNT_BITS-1:0]    pkt_pass_cnt,
  output logic [CNT_BITS-1:0]    pkt_drop_cnt,
  output logic                   drop_evt
);

  localparam int unsigned KEEP_BITS = DATA_BITS / 8;
  localparam int unsigned WAIT_BITS = (LOOKUP_LAT < 1) ? 1 : $clog2(LOOKUP_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_PASS,
    S_DROP
  } state_t;

  state_t               state_q, state_d;
  logic [WAIT_BITS-1:0] wait_cnt;
  logic [7:0]           route_reg;
  logic                 capture;
  logic                 route_ld;
  logic                 authorised;
  logic                 pass_done;
  logic                 drop_done;

  // State register
  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshake steering and combinational pass-through
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    capture       = 1'b0;
    route_ld      = 1'b0;
    pass_done     = 1'b0;
    drop_done     = 1'b0;
    authorised    = route_in[7] && (route_in[1:0] == ul_port_out);
    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid) begin
          capture = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (wait_cnt == '0) begin
          route_ld = 1'b1;
          state_d  = authorised ? S_PASS : S_DROP;
        end
      end
      S_PASS: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tlast  = s_axis_tlast;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          pass_done = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_done = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lookup index, wait counter and the once-per-packet capability snapshot
  always_ff @(posedge aclk) begin
    if (areset) begin
      ul_port_out <= '0;
      wait_cnt    <= '0;
      route_reg   <= '0;
    end else begin
      if (capture) begin
        ul_port_out <= s_ul_id;
        wait_cnt    <= WAIT_BITS'(LOOKUP_LAT);
      end else if (state_q == S_LOOKUP && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_BITS'(1);
      end
      if (route_ld) route_reg <= route_in;
    end
  end

  assign m_axis_tdest = route_reg;

  // Saturating packet counters; clear has priority over increment
  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_pass_cnt <= '0;
      pkt_drop_cnt <= '0;
      drop_evt     <= 1'b0;
    end else begin
      drop_evt <= drop_done;
      if (cnt_clr) begin
        pkt_pass_cnt <= '0;
        pkt_drop_cnt <= '0;
      end else begin
        if (pass_done && pkt_pass_cnt != '1) pkt_pass_cnt <= pkt_pass_cnt + CNT_BITS'(1);
        if (drop_done && pkt_drop_cnt != '1) pkt_drop_cnt <= pkt_drop_cnt + CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_gate_send_stamp.sv
// Randomized self-checking bench for gate_send_stamp with a behavioural route table.
module tb_gate_send_stamp;

  localparam int unsigned DATA_BITS  = 64;
  localparam int unsigned KEEP_BITS  = DATA_BITS / 8;
  localparam int unsigned LOOKUP_LAT = 1;
  localparam int unsigned CNT_BITS   = 4;
  localparam int          CNT_MAX    = (1 << CNT_BITS) - 1;
  localparam int          HDR_LAT    = LOOKUP_LAT + 2;

  logic                 aclk = 1'b0;
  logic                 areset;
  logic [DATA_BITS-1:0] s_axis_tdata;
  logic [KEEP_BITS-1:0] s_axis_tkeep;
  logic                 s_axis_tlast;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [1:0]           s_ul_id;
  logic [1:0]           ul_port_out;
  logic [7:0]           route_in;
  logic [DATA_BITS-1:0] m_axis_tdata;
  logic [KEEP_BITS-1:0] m_axis_tkeep;
  logic                 m_axis_tlast;
  logic [7:0]           m_axis_tdest;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 cnt_clr;
  logic [CNT_BITS-1:0]  pkt_pass_cnt;
  logic [CNT_BITS-1:0]  pkt_drop_cnt;
  logic                 drop_evt;

  gate_send_stamp #(
    .DATA_BITS (DATA_BITS),
    .LOOKUP_LAT(LOOKUP_LAT),
    .CNT_BITS  (CNT_BITS)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_ul_id      (s_ul_id),
    .ul_port_out  (ul_port_out),
    .route_in     (route_in),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tdest (m_axis_tdest),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .cnt_clr      (cnt_clr),
    .pkt_pass_cnt (pkt_pass_cnt),
    .pkt_drop_cnt (pkt_drop_cnt),
    .drop_evt     (drop_evt)
  );

  always #5 aclk = ~aclk;

  // Route table: one register stage between index and capability
  logic [7:0] tbl [4];
  always @(posedge aclk) begin
    if (areset) route_in <= 8'h00;
    else        route_in <= tbl[ul_port_out];
  end

  int drop_pulses = 0;
  always @(negedge aclk) if (drop_evt === 1'b1) drop_pulses++;

  int checks = 0;
  int failures = 0;
  int exp_pass = 0;
  int exp_drop = 0;

  logic [DATA_BITS-1:0] sent_d [$];
  logic [KEEP_BITS-1:0] sent_k [$];
  logic [DATA_BITS-1:0] got_d  [$];
  logic [KEEP_BITS-1:0] got_k  [$];
  logic                 got_l  [$];
  logic [7:0]           got_t  [$];
  int first_out_cyc, sready_cycs, mvalid_cycs;
  bit timed_out;

  function automatic bit authorised(input logic [7:0] cap, input logic [1:0] id);
    return cap[7] && (cap[1:0] == id);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic logic rdy_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // Drives one packet; returns at the start of the cycle after its last input handshake.
  task automatic run_pkt(input logic [1:0] id, input int n, input int mode,
                         input int rw_after, input logic [7:0] rw_val,
                         input int clr_cyc, input int abort_at);
    int cyc, idx;
    bit hs, rewritten;
    sent_d.delete(); sent_k.delete();
    got_d.delete(); got_k.delete(); got_l.delete(); got_t.delete();
    for (int i = 0; i < n; i++) begin
      sent_d.push_back({$urandom, $urandom});
      sent_k.push_back(KEEP_BITS'($urandom) | KEEP_BITS'(1));
    end
    first_out_cyc = -1; sready_cycs = 0; mvalid_cycs = 0; timed_out = 0;
    cyc = 0; idx = 0; rewritten = 0;
    cnt_clr       = 1'b0;
    s_ul_id       = id;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = sent_d[0];
    s_axis_tkeep  = sent_k[0];
    s_axis_tlast  = (n == 1);
    m_axis_tready = rdy_for(mode, cyc);
    forever begin
      @(negedge aclk);
      hs = s_axis_tvalid && s_axis_tready;
      if (s_axis_tready) sready_cycs++;
      if (m_axis_tvalid) mvalid_cycs++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (got_d.size() == 0) first_out_cyc = cyc;
        got_d.push_back(m_axis_tdata);
        got_k.push_back(m_axis_tkeep);
        got_l.push_back(m_axis_tlast);
        got_t.push_back(m_axis_tdest);
      end
      @(posedge aclk); #1;
      cyc++;
      cnt_clr = (cyc == clr_cyc);
      if (hs) idx++;
      if (rw_after >= 0 && !rewritten && got_d.size() >= rw_after) begin
        tbl[id] = rw_val;
        rewritten = 1;
      end
      if (idx == n) begin
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        break;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        areset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        break;
      end
      if (cyc > 300) begin
        timed_out = 1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        break;
      end
      s_axis_tdata  = sent_d[idx];
      s_axis_tkeep  = sent_k[idx];
      s_axis_tlast  = (idx == n - 1);
      m_axis_tready = rdy_for(mode, cyc);
    end
    cnt_clr = 1'b0;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    @(posedge aclk); #1;
    cnt_clr = 1'b0;
    exp_pass = 0; exp_drop = 0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, drop_evt} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b want=000", {s_axis_tready, m_axis_tvalid, drop_evt});
    end
    checks++;
    if ({m_axis_tdest, ul_port_out} !== 10'h0) begin
      failures++; $display("FAIL reset_dest_port got=%h want=0", {m_axis_tdest, ul_port_out});
    end
    checks++;
    if ({pkt_pass_cnt, pkt_drop_cnt} !== '0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d want=0/0", pkt_pass_cnt, pkt_drop_cnt);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  task automatic test_pass();
    tbl[1] = 8'h81;
    run_pkt(2'd1, 4, 0, -1, 8'h00, -1, -1);
    exp_pass = sat_inc(exp_pass);
    checks++;
    if (got_d.size() != 4 || timed_out) begin
      failures++; $display("FAIL pass_beats got=%0d want=4", got_d.size());
    end
    checks++;
    if (first_out_cyc != HDR_LAT) begin
      failures++; $display("FAIL pass_first_cycle got=%0d want=%0d", first_out_cyc, HDR_LAT);
    end
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      checks++;
      if (got_d[i] !== sent_d[i] || got_k[i] !== sent_k[i] || got_l[i] !== (i == 3) || got_t[i] !== 8'h81) begin
        failures++;
        $display("FAIL pass_beat%0d got=%h/%h/%b/%h want=%h/%h/%b/81", i, got_d[i], got_k[i], got_l[i], got_t[i],
                 sent_d[i], sent_k[i], (i == 3));
      end
    end
    checks++;
    if (pkt_pass_cnt !== CNT_BITS'(exp_pass)) begin
      failures++; $display("FAIL pass_cnt got=%0d want=%0d", pkt_pass_cnt, exp_pass);
    end
  endtask

  task automatic test_drop();
    int p0;
    tbl[2] = 8'h0A;
    p0 = drop_pulses;
    run_pkt(2'd2, 3, 0, -1, 8'h00, -1, -1);
    exp_drop = sat_inc(exp_drop);
    checks++;
    if (mvalid_cycs != 0) begin
      failures++; $display("FAIL drop_mvalid got=%0d want=0", mvalid_cycs);
    end
    checks++;
    if (sready_cycs != 3) begin
      failures++; $display("FAIL drop_sready_cycles got=%0d want=3", sready_cycs);
    end
    checks++;
    if (pkt_drop_cnt !== CNT_BITS'(exp_drop)) begin
      failures++; $display("FAIL drop_cnt got=%0d want=%0d", pkt_drop_cnt, exp_drop);
    end
    @(negedge aclk);
    @(posedge aclk); #1;
    checks++;
    if (drop_pulses - p0 != 1) begin
      failures++; $display("FAIL drop_evt_pulses got=%0d want=1", drop_pulses - p0);
    end
  endtask

  task automatic test_owner();
    tbl[3] = 8'h82;
    run_pkt(2'd3, 1, 0, -1, 8'h00, -1, -1);
    exp_drop = sat_inc(exp_drop);
    checks++;
    if (got_d.size() != 0 || pkt_drop_cnt !== CNT_BITS'(exp_drop)) begin
      failures++; $display("FAIL owner_mismatch beats=%0d drops=%0d want=0/%0d", got_d.size(), pkt_drop_cnt, exp_drop);
    end
    tbl[3] = 8'h83;
    run_pkt(2'd3, 1, 0, -1, 8'h00, -1, -1);
    exp_pass = sat_inc(exp_pass);
    checks++;
    if (got_d.size() != 1 || got_t[0] !== 8'h83 || got_d[0] !== sent_d[0] || got_l[0] !== 1'b1) begin
      failures++; $display("FAIL owner_match beats=%0d tdest=%h want=1/83", got_d.size(), (got_t.size() > 0) ? got_t[0] : 8'hxx);
    end
    checks++;
    if (pkt_pass_cnt !== CNT_BITS'(exp_pass)) begin
      failures++; $display("FAIL owner_pass_cnt got=%0d want=%0d", pkt_pass_cnt, exp_pass);
    end
  endtask

  task automatic test_backpressure();
    tbl[1] = 8'h81;
    run_pkt(2'd1, 8, 1, 3, 8'h00, -1, -1);
    exp_pass = sat_inc(exp_pass);
    checks++;
    if (got_d.size() != 8 || timed_out) begin
      failures++; $display("FAIL bp_beats got=%0d want=8", got_d.size());
    end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      checks++;
      if (got_d[i] !== sent_d[i] || got_t[i] !== 8'h81 || got_l[i] !== (i == 7)) begin
        failures++; $display("FAIL bp_beat%0d got=%h/%h want=%h/81", i, got_d[i], got_t[i], sent_d[i]);
      end
    end
    checks++;
    if (pkt_pass_cnt !== CNT_BITS'(exp_pass)) begin
      failures++; $display("FAIL bp_pass_cnt got=%0d want=%0d", pkt_pass_cnt, exp_pass);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] id;
    logic [7:0] cap;
    int n;
    bit ok;
    for (int k = 0; k < 10; k++) begin
      id  = 2'($urandom);
      cap = $urandom_range(0, 1) ? {1'b1, 5'($urandom), id} : 8'($urandom);
      tbl[id] = cap;
      n  = $urandom_range(1, 5);
      ok = authorised(cap, id);
      run_pkt(id, n, 2, -1, 8'h00, -1, -1);
      if (ok) exp_pass = sat_inc(exp_pass);
      else    exp_drop = sat_inc(exp_drop);
      checks++;
      if (got_d.size() != (ok ? n : 0) || timed_out) begin
        failures++; $display("FAIL b2b%0d_beats got=%0d want=%0d", k, got_d.size(), ok ? n : 0);
      end
      for (int i = 0; i < got_d.size() && i < n; i++) begin
        checks++;
        if (got_d[i] !== sent_d[i] || got_k[i] !== sent_k[i] || got_t[i] !== cap) begin
          failures++; $display("FAIL b2b%0d_beat%0d got=%h/%h want=%h/%h", k, i, got_d[i], got_t[i], sent_d[i], cap);
        end
      end
      checks++;
      if (pkt_pass_cnt !== CNT_BITS'(exp_pass) || pkt_drop_cnt !== CNT_BITS'(exp_drop)) begin
        failures++; $display("FAIL b2b%0d_cnt got=%0d/%0d want=%0d/%0d", k, pkt_pass_cnt, pkt_drop_cnt, exp_pass, exp_drop);
      end
    end
  endtask

  task automatic test_saturation();
    clear_counters();
    tbl[0] = 8'h00;
    for (int k = 0; k < CNT_MAX + 1; k++) begin
      run_pkt(2'd0, 1, 2, -1, 8'h00, -1, -1);
      exp_drop = sat_inc(exp_drop);
      checks++;
      if (pkt_drop_cnt !== CNT_BITS'(exp_drop)) begin
        failures++; $display("FAIL sat_drop%0d got=%0d want=%0d", k, pkt_drop_cnt, exp_drop);
      end
    end
    tbl[1] = 8'h81;
    run_pkt(2'd1, 1, 0, -1, 8'h00, -1, -1);
    exp_pass = sat_inc(exp_pass);
    run_pkt(2'd1, 1, 0, -1, 8'h00, HDR_LAT, -1);
    exp_pass = 0; exp_drop = 0;
    checks++;
    if (pkt_pass_cnt !== CNT_BITS'(exp_pass) || pkt_drop_cnt !== CNT_BITS'(exp_drop)) begin
      failures++; $display("FAIL clr_vs_inc got=%0d/%0d want=0/0", pkt_pass_cnt, pkt_drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    tbl[1] = 8'h81;
    run_pkt(2'd1, 5, 0, -1, 8'h00, -1, 2);
    checks++;
    if (got_d.size() != 2) begin
      failures++; $display("FAIL rst_mid_prefix got=%0d want=2", got_d.size());
    end
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_pass = 0; exp_drop = 0;
    @(negedge aclk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, drop_evt, m_axis_tlast} !== 4'b0000 || m_axis_tdata !== '0) begin
      failures++; $display("FAIL rst_mid_flags got=%b data=%h want=0000/0",
                           {s_axis_tready, m_axis_tvalid, drop_evt, m_axis_tlast}, m_axis_tdata);
    end
    checks++;
    if ({m_axis_tdest, ul_port_out, pkt_pass_cnt, pkt_drop_cnt} !== '0) begin
      failures++; $display("FAIL rst_mid_regs tdest=%h port=%0d cnt=%0d/%0d want=0", m_axis_tdest, ul_port_out,
                           pkt_pass_cnt, pkt_drop_cnt);
    end
    @(posedge aclk); #1;
    run_pkt(2'd1, 3, 0, -1, 8'h00, -1, -1);
    exp_pass = sat_inc(exp_pass);
    checks++;
    if (got_d.size() != 3 || first_out_cyc != HDR_LAT || got_d[0] !== sent_d[0] || got_t[0] !== 8'h81) begin
      failures++; $display("FAIL rst_mid_after beats=%0d first=%0d want=3/%0d", got_d.size(), first_out_cyc, HDR_LAT);
    end
    checks++;
    if (pkt_pass_cnt !== CNT_BITS'(exp_pass)) begin
      failures++; $display("FAIL rst_mid_pass_cnt got=%0d want=%0d", pkt_pass_cnt, exp_pass);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tbl[i] = 8'h00;
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_ul_id       = 2'd0;
    m_axis_tready = 1'b0;
    cnt_clr       = 1'b0;
    test_reset();
    test_pass();
    test_drop();
    test_owner();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    repeat (2) @(posedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
